// File: rtl/dut_fsm_generator.sv
// Stimulus-side FSM for the DUT FSM SEU test path: cycles data codes 1-2-3 onto the
// checker bus, flags illegal states, and holds an all-ones recovery code in S_ERR.
module dut_fsm_generator #(
    parameter int unsigned IO_SIZE_G  = 4,
    parameter int unsigned ERR_HOLD_G = 2,
    parameter int unsigned CNT_W_G    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 inj_state_i,
    input  logic                 inj_skip_i,
    output logic [IO_SIZE_G-1:0] data_o,
    output logic                 state_err_o,
    output logic                 busy_o,
    output logic [CNT_W_G-1:0]   loop_cnt_o,
    output logic [CNT_W_G-1:0]   err_cnt_o
);

    localparam int unsigned HOLD_W = (ERR_HOLD_G > 1) ? $clog2(ERR_HOLD_G) : 1;
    localparam logic [2:0]  S_INJ  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_ONE   = 3'b001,
        S_TWO   = 3'b010,
        S_THREE = 3'b011,
        S_ERR   = 3'b100
    } state_e;

    state_e                state_q, state_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [IO_SIZE_G-1:0]  data_q, data_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [CNT_W_G-1:0]    loop_q, loop_d;
    logic [CNT_W_G-1:0]    errc_q, errc_d;

    // Next state, hold counter and registered bus/status outputs
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        err_d   = 1'b0;
        loop_d  = loop_q;
        errc_d  = errc_q;
        data_d  = '0;
        busy_d  = (state_q != S_IDLE);

        case (state_q)
            S_IDLE:  if (en_i) state_d = S_ONE;
            S_ONE:   if (en_i) state_d = inj_skip_i ? S_THREE : S_TWO;
            S_TWO:   if (en_i) state_d = S_THREE;
            S_THREE: if (en_i) state_d = S_IDLE;
            S_ERR: begin
                if (hold_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = S_ERR;
                hold_d  = HOLD_W'(ERR_HOLD_G - 1);
                err_d   = 1'b1;
            end
        endcase

        // Upset injection overrides every transition except reset
        if (inj_state_i) state_d = state_e'(S_INJ);

        if (state_q == S_THREE && state_d == S_IDLE) loop_d = loop_q + CNT_W_G'(1);
        if (err_d && errc_q != '1) errc_d = errc_q + CNT_W_G'(1);

        case (state_q)
            S_IDLE:  data_d = '0;
            S_ONE:   data_d = IO_SIZE_G'(1);
            S_TWO:   data_d = IO_SIZE_G'(2);
            S_THREE: data_d = IO_SIZE_G'(3);
            S_ERR:   data_d = '1;
            default: data_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            loop_q  <= '0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            loop_q  <= loop_d;
            errc_q  <= errc_d;
        end
    end

    assign data_o      = data_q;
    assign state_err_o = err_q;
    assign busy_o      = busy_q;
    assign loop_cnt_o  = loop_q;
    assign err_cnt_o   = errc_q;

endmodule

// File: tb/tb_dut_fsm_generator.sv
// Directed bench for dut_fsm_generator: loop sequencing, enable gaps, skip, upset
// injection/recovery, error-count saturation (narrow counter instance) and reset in S_ERR.
module tb_dut_fsm_generator;

    logic        clk = 1'b0;
    logic        rst, en, inj, skip;
    logic [3:0]  data;
    logic        err, busy;
    logic [15:0] loop_cnt, err_cnt;

    logic        rst2, inj2;
    logic [3:0]  data2;
    logic        err2, busy2;
    logic [1:0]  loop2, errc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dut_fsm_generator #(.IO_SIZE_G(4), .ERR_HOLD_G(2), .CNT_W_G(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .inj_state_i(inj), .inj_skip_i(skip),
        .data_o(data), .state_err_o(err), .busy_o(busy),
        .loop_cnt_o(loop_cnt), .err_cnt_o(err_cnt)
    );

    dut_fsm_generator #(.IO_SIZE_G(4), .ERR_HOLD_G(2), .CNT_W_G(2)) u_dut_sat (
        .clk_i(clk), .rst_i(rst2), .en_i(1'b0), .inj_state_i(inj2), .inj_skip_i(1'b0),
        .data_o(data2), .state_err_o(err2), .busy_o(busy2),
        .loop_cnt_o(loop2), .err_cnt_o(errc2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1; en = 1'b0; inj = 1'b0; skip = 1'b0; inj2 = 1'b0;
        tick(); tick();
        rst = 1'b0; rst2 = 1'b0;
        checks++;
        if (data !== 4'd0 || err !== 1'b0 || busy !== 1'b0 || loop_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset: data=%0d err=%0b busy=%0b loop=%0d errc=%0d, expected all 0",
                     data, err, busy, loop_cnt, err_cnt);
        end
        checks++;
        if (data2 !== 4'd0 || errc2 !== 2'd0 || loop2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_sat: data=%0d errc=%0d loop=%0d, expected 0", data2, errc2, loop2);
        end
    endtask

    task automatic test_en_run();
        logic [3:0] exp_d;
        en = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp_d = 4'((n - 1) % 4);
            checks++;
            if (data !== exp_d || busy !== (exp_d != 4'd0) || err !== 1'b0) begin
                errors++;
                $display("FAIL run[%0d]: data=%0d busy=%0b err=%0b, expected data=%0d busy=%0b err=0",
                         n, data, busy, err, exp_d, (exp_d != 4'd0));
            end
            if (n == 17) begin
                checks++;
                if (loop_cnt !== 16'd4) begin
                    errors++;
                    $display("FAIL run_loop17: got %0d expected 4", loop_cnt);
                end
            end
        end
        en = 1'b0;
        checks++;
        if (loop_cnt !== 16'd5) begin
            errors++;
            $display("FAIL run_loop20: got %0d expected 5", loop_cnt);
        end
    endtask

    task automatic test_en_gaps();
        logic       en_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] exp_d  [6] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
        for (int i = 0; i < 6; i++) begin
            en = en_seq[i];
            tick();
            checks++;
            if (data !== exp_d[i]) begin
                errors++;
                $display("FAIL gap[%0d]: data=%0d expected %0d", i, data, exp_d[i]);
            end
        end
        en = 1'b0;
        checks++;
        if (loop_cnt !== 16'd6) begin
            errors++;
            $display("FAIL gap_loop: got %0d expected 6", loop_cnt);
        end
    endtask

    task automatic test_skip();
        logic [3:0] exp_d [4] = '{4'd0, 4'd1, 4'd3, 4'd0};
        logic       seen2;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            skip = (i == 1);
            tick();
            checks++;
            if (data !== exp_d[i]) begin
                errors++;
                $display("FAIL skip[%0d]: data=%0d expected %0d", i, data, exp_d[i]);
            end
        end
        checks++;
        if (loop_cnt !== 16'd7) begin
            errors++;
            $display("FAIL skip_loop: got %0d expected 7", loop_cnt);
        end
        // 16-cycle window with skip held: loops are IDLE-ONE-THREE, so code 2 never shows
        skip = 1'b1;
        seen2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (data === 4'd2) seen2 = 1'b1;
        end
        checks++;
        if (seen2 !== 1'b0 || loop_cnt !== 16'd12) begin
            errors++;
            $display("FAIL skip_window: seen2=%0b loop=%0d, expected seen2=0 loop=12", seen2, loop_cnt);
        end
        skip = 1'b0;
        tick();
        // skip with en low in S_ONE must not be latched
        tick();
        en = 1'b0; skip = 1'b1;
        tick();
        en = 1'b1; skip = 1'b0;
        tick(); tick();
        checks++;
        if (data !== 4'd2) begin
            errors++;
            $display("FAIL skip_ignored: data=%0d expected 2", data);
        end
        tick();
        en = 1'b0;
        checks++;
        if (loop_cnt !== 16'd14 || data !== 4'd3) begin
            errors++;
            $display("FAIL skip_tail: loop=%0d data=%0d, expected loop=14 data=3", loop_cnt, data);
        end
    endtask

    task automatic test_inject();
        logic [3:0] exp_d   [5] = '{4'd2, 4'd0, 4'd15, 4'd15, 4'd0};
        logic       exp_err [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        en = 1'b1;
        tick(); tick();
        inj = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) en = 1'b0;
            tick();
            inj = 1'b0;
            checks++;
            if (data !== exp_d[i] || err !== exp_err[i]) begin
                errors++;
                $display("FAIL inject[%0d]: data=%0d err=%0b expected data=%0d err=%0b",
                         i, data, err, exp_d[i], exp_err[i]);
            end
        end
        checks++;
        if (err_cnt !== 16'd1 || busy !== 1'b0 || loop_cnt !== 16'd14) begin
            errors++;
            $display("FAIL inject_end: errc=%0d busy=%0b loop=%0d expected errc=1 busy=0 loop=14",
                     err_cnt, busy, loop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_d   [7] = '{4'd0, 4'd0, 4'd15, 4'd0, 4'd15, 4'd15, 4'd0};
        logic       exp_err [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            inj = (i == 0 || i == 2);
            tick();
            checks++;
            if (data !== exp_d[i] || err !== exp_err[i]) begin
                errors++;
                $display("FAIL reinject[%0d]: data=%0d err=%0b expected data=%0d err=%0b",
                         i, data, err, exp_d[i], exp_err[i]);
            end
        end
        inj = 1'b0;
        checks++;
        if (err_cnt !== 16'd3) begin
            errors++;
            $display("FAIL reinject_cnt: got %0d expected 3", err_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c;
        for (int i = 0; i < 4; i++) begin
            inj2 = 1'b1;
            tick();
            inj2 = 1'b0;
            tick(); tick(); tick();
            exp_c = (i < 3) ? 2'(i + 1) : 2'd3;
            checks++;
            if (errc2 !== exp_c) begin
                errors++;
                $display("FAIL sat[%0d]: errc=%0d expected %0d", i, errc2, exp_c);
            end
        end
        tick();
        checks++;
        if (data2 !== 4'd0 || busy2 !== 1'b0 || err2 !== 1'b0 || loop2 !== 2'd0) begin
            errors++;
            $display("FAIL sat_idle: data=%0d busy=%0b err=%0b loop=%0d expected 0",
                     data2, busy2, err2, loop2);
        end
    endtask

    task automatic test_reset_in_err();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL rst_err_pre: err=%0b expected 1", err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (data !== 4'd0 || err !== 1'b0 || busy !== 1'b0 || loop_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_err: data=%0d err=%0b busy=%0b loop=%0d errc=%0d expected all 0",
                     data, err, busy, loop_cnt, err_cnt);
        end
        tick();
        checks++;
        if (data !== 4'd0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_err_after: data=%0d busy=%0b err=%0b expected 0", data, busy, err);
        end
        // Reset while the state register holds an illegal code
        inj = 1'b1;
        tick();
        inj = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (err !== 1'b0 || err_cnt !== 16'd0 || data !== 4'd0) begin
            errors++;
            $display("FAIL rst_illegal: err=%0b errc=%0d data=%0d expected 0", err, err_cnt, data);
        end
    endtask

    initial begin
        test_reset();
        test_en_run();
        test_en_gaps();
        test_skip();
        test_inject();
        test_back_to_back();
        test_saturation();
        test_reset_in_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
